// File: rtl/bank_shift_refresher_pkg.sv
// rtl/bank_shift_refresher_pkg.sv - shared types and default sizes for the shift-refresh responder
package gc_ref_pkg;

  localparam int DEF_ROWS = 128;
  localparam int DEF_AW   = 7;
  localparam int DEF_DW   = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COPY  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } ref_state_e;

endpackage

// File: rtl/bank_shift_refresher_hold_buf.sv
// rtl/bank_shift_refresher_hold_buf.sv - one-entry row buffer between source read and destination write
module ref_hold_buf
  import gc_ref_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_tag,
  input  logic [DW-1:0] src_rd,
  input  logic          fwd_we,
  input  logic [AW-1:0] fwd_addr,
  input  logic [DW-1:0] fwd_data,
  input  logic          stall,
  output logic          valid,
  output logic          ready,
  output logic          wb_we,
  output logic [AW-1:0] wb_tag,
  output logic [DW-1:0] wb_data
);

  logic          valid_q, valid_d;
  logic          live_q, live_d;
  logic [AW-1:0] tag_q, tag_d;
  logic [DW-1:0] data_q, data_d;
  logic          hit, ld_hit;
  logic [DW-1:0] cur_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      live_q  <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      live_q  <= live_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  // live: the entry's data is still arriving on src_rd and has not been latched yet
  always_comb begin
    hit      = valid_q && fwd_we && (fwd_addr == tag_q);
    ld_hit   = ld_en && fwd_we && (fwd_addr == ld_tag);
    cur_data = hit ? fwd_data : (live_q ? src_rd : data_q);
    valid    = valid_q;
    wb_we    = valid_q && !stall;
    ready    = !valid_q || !stall;
    wb_tag   = valid_q ? tag_q : '0;
    wb_data  = valid_q ? cur_data : '0;
    valid_d  = valid_q;
    live_d   = live_q;
    tag_d    = tag_q;
    data_d   = data_q;
    if (ld_en) begin
      valid_d = 1'b1;
      tag_d   = ld_tag;
      live_d  = !ld_hit;
      data_d  = fwd_data;
    end else if (wb_we) begin
      valid_d = 1'b0;
      live_d  = 1'b0;
    end else if (valid_q) begin
      data_d  = cur_data;
      live_d  = 1'b0;
    end
  end

endmodule

// File: rtl/bank_shift_refresher.sv
// rtl/bank_shift_refresher.sv - copies the source bank into the spare bank on start_sr, keeping user traffic coherent
module bank_shift_refresher
  import gc_ref_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_sr,
  input  logic          usr_we,
  input  logic          usr_re,
  input  logic [AW-1:0] usr_waddr,
  input  logic [AW-1:0] usr_raddr,
  input  logic [DW-1:0] usr_wdata,
  input  logic [DW-1:0] src_rd,
  output logic          src_re,
  output logic [AW-1:0] src_raddr,
  output logic          dst_we,
  output logic [AW-1:0] dst_waddr,
  output logic [DW-1:0] dst_wdata,
  output logic          busy,
  output logic          ref_done,
  output logic          offs_ref_re
);

  ref_state_e    state_q, state_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cmt_q, cmt_d;
  logic          mirror, eng_re;
  logic          buf_valid, buf_ready, buf_we;
  logic [AW-1:0] buf_tag;
  logic [DW-1:0] buf_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      cmt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      cmt_q    <= cmt_d;
    end
  end

  ref_hold_buf #(.AW(AW), .DW(DW)) u_hold (
    .clk      (clk),
    .rst_n    (rst),
    .ld_en    (eng_re),
    .ld_tag   (rd_ptr_q[AW-1:0]),
    .src_rd   (src_rd),
    .fwd_we   (usr_we && busy),
    .fwd_addr (usr_waddr),
    .fwd_data (usr_wdata),
    .stall    (mirror),
    .valid    (buf_valid),
    .ready    (buf_ready),
    .wb_we    (buf_we),
    .wb_tag   (buf_tag),
    .wb_data  (buf_data)
  );

  // rows below cmt already live in dst, so user writes there must be mirrored
  always_comb begin
    busy     = (state_q == COPY) || (state_q == FLUSH);
    ref_done = (state_q == DONE) && !start_sr;
    mirror   = busy && usr_we && ({1'b0, usr_waddr} < cmt_q);
    eng_re   = (state_q == COPY) && !usr_re && buf_ready;

    src_re      = rst && (eng_re || usr_re);
    src_raddr   = !rst ? '0 : (eng_re ? rd_ptr_q[AW-1:0] : usr_raddr);
    dst_we      = mirror || buf_we;
    dst_waddr   = mirror ? usr_waddr : buf_tag;
    dst_wdata   = mirror ? usr_wdata : buf_data;
    offs_ref_re = usr_re && (busy || ref_done) && (ref_done || ({1'b0, usr_raddr} < cmt_q));

    state_d  = state_q;
    rd_ptr_d = rd_ptr_q + (AW+1)'(eng_re);
    cmt_d    = cmt_q + (AW+1)'(buf_we);
    case (state_q)
      IDLE, DONE: begin
        if (start_sr) begin
          state_d  = COPY;
          rd_ptr_d = '0;
          cmt_d    = '0;
        end
      end
      COPY: begin
        if (eng_re && (rd_ptr_q == (AW+1)'(ROWS - 1))) state_d = FLUSH;
      end
      FLUSH: begin
        if (!buf_valid || buf_we) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
